// File: rtl/sample_iterator.sv
// Walks every subsample position of a triangle's bounding box in raster order.
// Optional SAMPLE_ITER_STATS_EN adds sample and triangle counters.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    input  logic                     halt_RnnnnH,
    output logic                     halt_up_R13H,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
`ifdef SAMPLE_ITER_STATS_EN
    ,
    output logic        [31:0]       samp_cnt_RnnnnU,
    output logic        [31:0]       tri_cnt_RnnnnU
`endif
);

    typedef enum logic {WAIT, TEST} state_t;

    localparam logic [SIGFIG-1:0] STEP_1PX  = SIGFIG'(1) << RADIX;
    localparam logic [SIGFIG-1:0] STEP_4PX  = SIGFIG'(1) << (RADIX - 1);
    localparam logic [SIGFIG-1:0] STEP_16PX = SIGFIG'(1) << (RADIX - 2);
    localparam logic [SIGFIG-1:0] STEP_64PX = SIGFIG'(1) << (RADIX - 3);

    state_t state_q, state_d;

    logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];
    logic        [SIGFIG-1:0] color_d [COLORS];
    logic signed [SIGFIG-1:0] ll_q [2];
    logic signed [SIGFIG-1:0] ll_d [2];
    logic signed [SIGFIG-1:0] ur_q [2];
    logic signed [SIGFIG-1:0] ur_d [2];
    logic signed [SIGFIG-1:0] sample_q [2];
    logic signed [SIGFIG-1:0] sample_d [2];
    logic        [SIGFIG-1:0] step_q, step_d;
    logic                     valid_q, valid_d;

    logic                     accept;
    logic                     box_empty;
    logic        [SIGFIG-1:0] step_in;
    logic signed [SIGFIG:0]   nx, ny;
    logic                     x_fits, y_fits;

    // Anything other than a clean one-hot falls back to one sample per pixel.
    always_comb begin
        case (subSample_RnnnnU)
            4'b0100: step_in = STEP_4PX;
            4'b0010: step_in = STEP_16PX;
            4'b0001: step_in = STEP_64PX;
            default: step_in = STEP_1PX;
        endcase
    end

    assign accept    = (state_q == WAIT) && validTri_R13H && !halt_RnnnnH;
    assign box_empty = (box_R13S[1][0] < box_R13S[0][0]) || (box_R13S[1][1] < box_R13S[0][1]);

    // One extra bit keeps the increment from wrapping past ur.
    assign nx     = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed({1'b0, step_q});
    assign ny     = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed({1'b0, step_q});
    assign x_fits = nx <= $signed({ur_q[0][SIGFIG-1], ur_q[0]});
    assign y_fits = ny <= $signed({ur_q[1][SIGFIG-1], ur_q[1]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT;
            tri_q    <= '{default: '{default: '0}};
            color_q  <= '{default: '0};
            ll_q     <= '{default: '0};
            ur_q     <= '{default: '0};
            sample_q <= '{default: '0};
            step_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            ll_q     <= ll_d;
            ur_q     <= ur_d;
            sample_q <= sample_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT: if (accept && !box_empty) state_d = TEST;
            TEST: if (!halt_RnnnnH && !x_fits && !y_fits) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    // Empty boxes are consumed without touching the held triangle or position.
    always_comb begin
        tri_d    = tri_q;
        color_d  = color_q;
        ll_d     = ll_q;
        ur_d     = ur_q;
        sample_d = sample_q;
        step_d   = step_q;
        valid_d  = valid_q;
        if (accept && !box_empty) begin
            tri_d       = tri_R13S;
            color_d     = color_R13U;
            step_d      = step_in;
            ll_d[0]     = box_R13S[0][0];
            ll_d[1]     = box_R13S[0][1];
            ur_d[0]     = box_R13S[1][0];
            ur_d[1]     = box_R13S[1][1];
            sample_d[0] = box_R13S[0][0];
            sample_d[1] = box_R13S[0][1];
            valid_d     = 1'b1;
        end else if (state_q == TEST && !halt_RnnnnH) begin
            if (x_fits) begin
                sample_d[0] = nx[SIGFIG-1:0];
            end else begin
                sample_d[0] = ll_q[0];
                if (y_fits) sample_d[1] = ny[SIGFIG-1:0];
                else        valid_d     = 1'b0;
            end
        end
    end

    assign halt_up_R13H   = (state_q == TEST) || halt_RnnnnH;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;
    assign validSamp_R14H = valid_q;

`ifdef SAMPLE_ITER_STATS_EN
    logic [31:0] samp_cnt_q, samp_cnt_d;
    logic [31:0] tri_cnt_q, tri_cnt_d;

    always_comb begin
        samp_cnt_d = samp_cnt_q + 32'(valid_q && !halt_RnnnnH);
        tri_cnt_d  = tri_cnt_q + 32'(accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt_q <= '0;
            tri_cnt_q  <= '0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
            tri_cnt_q  <= tri_cnt_d;
        end
    end

    assign samp_cnt_RnnnnU = samp_cnt_q;
    assign tri_cnt_RnnnnU  = tri_cnt_q;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: vector table plus hand-written stall,
// back-to-back, empty-box and reset sequences.
module tb_sample_iterator;

    logic clk = 1'b0;
    logic rst;
    logic signed [23:0] tri_in  [3][3];
    logic signed [23:0] tri_out [3][3];
    logic        [23:0] color_in  [3];
    logic        [23:0] color_out [3];
    logic signed [23:0] box_in [2][2];
    logic signed [23:0] samp [2];
    logic               valid_tri, halt, halt_up, valid_samp;
    logic        [3:0]  sub;
`ifdef SAMPLE_ITER_STATS_EN
    logic        [31:0] samp_cnt, tri_cnt;
`endif

    sample_iterator #(.SIGFIG(24), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (sub),
        .halt_RnnnnH      (halt),
        .halt_up_R13H     (halt_up),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (samp),
        .validSamp_R14H   (valid_samp)
`ifdef SAMPLE_ITER_STATS_EN
        ,
        .samp_cnt_RnnnnU  (samp_cnt),
        .tri_cnt_RnnnnU   (tri_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int qx[$];
    int qy[$];

    typedef struct {
        int         llx, lly, urx, ury;
        logic [3:0] sub;
        int         n;
        int         lastx, lasty;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int qx_at(input int i);
        return (i < qx.size()) ? qx[i] : 32'h7fff_ffff;
    endfunction

    function automatic int qy_at(input int i);
        return (i < qy.size()) ? qy[i] : 32'h7fff_ffff;
    endfunction

    task automatic present(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] s, input int seed);
        box_in[0][0] = 24'(llx);
        box_in[0][1] = 24'(lly);
        box_in[1][0] = 24'(urx);
        box_in[1][1] = 24'(ury);
        sub = s;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_in[v][a] = 24'(seed * 100 + v * 10 + a + 1);
        for (int c = 0; c < 3; c++) color_in[c] = 24'(seed * 1000 + c + 7);
        valid_tri = 1'b1;
    endtask

    // Collect consumed samples until validSamp drops; ends on a negedge.
    task automatic collect(input int budget, output int n, output bit timeout);
        qx.delete();
        qy.delete();
        timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!valid_samp) begin
                timeout = 1'b0;
                break;
            end
            if (!halt) begin
                qx.push_back(int'(samp[0]));
                qy.push_back(int'(samp[1]));
            end
        end
        n = qx.size();
    endtask

    initial begin
        int n, nvalid, held;
        bit to, done;
        logic [9:0] pat;
        int bx [4];
        int by [4];
        bx = '{0, 1024, 0, 1024};
        by = '{0, 0, 1024, 1024};

        vecs[0] = '{0, 0, 1024, 1024, 4'b1000, 4, 1024, 1024};
        vecs[1] = '{0, 0, 512, 512, 4'b0100, 4, 512, 512};
        vecs[2] = '{0, 0, 256, 512, 4'b0010, 6, 256, 512};
        vecs[3] = '{-128, -128, 128, 0, 4'b0001, 6, 128, 0};
        vecs[4] = '{0, 0, 1024, 0, 4'b0110, 2, 1024, 0};
        vecs[5] = '{2048, 0, 1024, 0, 4'b1000, 0, 0, 0};
        vecs[6] = '{3072, -2048, 3072, -2048, 4'b1000, 1, 3072, -2048};
        vecs[7] = '{0, 1024, 0, 0, 4'b0000, 0, 0, 0};

        rst = 1'b1;
        halt = 1'b0;
        valid_tri = 1'b0;
        sub = 4'b1000;
        tri_in = '{default: '{default: '0}};
        color_in = '{default: '0};
        box_in = '{default: '{default: '0}};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", valid_samp, 0);
        chk("rst_halt_up", halt_up, 0);
        chk("rst_samp_x", samp[0], 0);
        chk("rst_tri", tri_out[2][2], 0);
        chk("rst_color", color_out[1], 0);
        rst = 1'b0;

        // Basic 1 sample/px; subSample changed after accept must not matter
        @(negedge clk);
        present(0, 0, 1024, 1024, 4'b1000, 1);
        chk("basic_halt_up_idle", halt_up, 0);
        @(posedge clk);
        #1;
        valid_tri = 1'b0;
        sub = 4'b0001;
        chk("basic_first_latency", valid_samp, 1);
        chk("basic_halt_up_busy", halt_up, 1);
        collect(50, n, to);
        chk("basic_timeout", to, 0);
        chk("basic_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_x%0d", i), qx_at(i), bx[i]);
            chk($sformatf("basic_y%0d", i), qy_at(i), by[i]);
        end
        chk("basic_halt_up_done", halt_up, 0);
        chk("basic_tri_held", tri_out[1][2], 113);
        chk("basic_color_held", color_out[2], 1009);

        // Empty box dropped, next triangle accepted the following cycle
        present(2048, 0, 1024, 0, 4'b1000, 2);
        @(posedge clk);
        #1;
        present(0, 0, 512, 512, 4'b0100, 3);
        @(negedge clk);
        chk("empty_valid", valid_samp, 0);
        chk("empty_halt_up", halt_up, 0);
        chk("empty_tri_kept", tri_out[0][0], 101);
`ifdef SAMPLE_ITER_STATS_EN
        chk("stats_samp_cnt", samp_cnt, 4);
        chk("stats_tri_cnt", tri_cnt, 2);
`endif
        @(posedge clk);
        #1;
        valid_tri = 1'b0;
        chk("after_empty_valid", valid_samp, 1);
        collect(50, n, to);
        chk("after_empty_timeout", to, 0);
        chk("after_empty_count", n, 4);
        chk("after_empty_x1", qx_at(1), 512);
        chk("after_empty_y3", qy_at(3), 512);

        // Back-to-back: upstream holds validTri; exactly one idle cycle between
        present(0, 0, 512, 512, 4'b0100, 4);
        pat = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pat[9 - c] = valid_samp;
            if (c == 5) valid_tri = 1'b0;
        end
        chk("b2b_pattern", pat, 10'b1111011110);

        // Downstream stall on the 2nd sample for 3 cycles
        present(0, 0, 1024, 1024, 4'b1000, 5);
        @(posedge clk);
        #1;
        valid_tri = 1'b0;
        qx.delete();
        qy.delete();
        nvalid = 0;
        held = 0;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            halt = (c >= 1 && c <= 3);
            if (!valid_samp) begin
                done = 1'b1;
                break;
            end
            nvalid++;
            if (halt && samp[0] == 1024 && samp[1] == 0) held++;
            if (!halt) begin
                qx.push_back(int'(samp[0]));
                qy.push_back(int'(samp[1]));
            end
        end
        halt = 1'b0;
        chk("stall_timeout", done, 1);
        chk("stall_valid_cycles", nvalid, 7);
        chk("stall_held", held, 3);
        chk("stall_count", qx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_x%0d", i), qx_at(i), bx[i]);
            chk($sformatf("stall_y%0d", i), qy_at(i), by[i]);
        end

        // Asynchronous reset during the 2nd sample
        present(0, 0, 1024, 1024, 4'b1000, 6);
        @(posedge clk);
        #1;
        valid_tri = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_pre_x", samp[0], 1024);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid_samp, 0);
        chk("mid_rst_x", samp[0], 0);
        chk("mid_rst_tri", tri_out[0][0], 0);
        chk("mid_rst_color", color_out[0], 0);
        @(negedge clk);
        rst = 1'b0;
        present(-1024, 512, 0, 512, 4'b1000, 7);
        @(posedge clk);
        #1;
        valid_tri = 1'b0;
        collect(50, n, to);
        chk("post_rst_timeout", to, 0);
        chk("post_rst_count", n, 2);
        chk("post_rst_x0", qx_at(0), -1024);
        chk("post_rst_y0", qy_at(0), 512);
        chk("post_rst_x1", qx_at(1), 0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            present(vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury, vecs[i].sub, 10 + i);
            @(posedge clk);
            #1;
            valid_tri = 1'b0;
            collect(100, n, to);
            chk($sformatf("v%0d_timeout", i), to, 0);
            chk($sformatf("v%0d_count", i), n, vecs[i].n);
            chk($sformatf("v%0d_halt_up", i), halt_up, 0);
            if (vecs[i].n > 0) begin
                chk($sformatf("v%0d_first_x", i), qx_at(0), vecs[i].llx);
                chk($sformatf("v%0d_first_y", i), qy_at(0), vecs[i].lly);
                chk($sformatf("v%0d_last_x", i), qx_at(n - 1), vecs[i].lastx);
                chk($sformatf("v%0d_last_y", i), qy_at(n - 1), vecs[i].lasty);
                chk($sformatf("v%0d_tri", i), tri_out[2][1], (10 + i) * 100 + 22);
                chk($sformatf("v%0d_color", i), color_out[1], (10 + i) * 1000 + 8);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
